// File: rtl/fetch_unit_pkg.sv
// Shared constants, FSM state type and helpers for the instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_BOOT   = 2'd0,
    FS_RUN    = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head output holds the last popped entry while empty.
module fetch_fifo #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] last_reg;
  logic             do_pop;

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == DEPTH_C);
  assign count  = count_reg;
  assign do_pop = pop && !empty;
  assign rdata  = empty ? last_reg : mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      last_reg   <= RESET_VAL;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        last_reg   <= mem[rd_ptr_reg];
      end
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, issues credit-limited imem reads and buffers
// {inst, pc} pairs toward decode; redirects flush buffered and in-flight words.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(MAX_OUTST);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [OW:0]  outst_reg, outst_next;
  logic [OW:0]  drop_reg, drop_next;

  logic         outst_ok, credit_ok, req_fire, pop_fire;
  logic         resp_push, resp_drop, pcq_pop;
  logic [CW:0]  buf_count;
  logic         buf_full, buf_empty;
  logic [63:0]  buf_rdata;
  logic [31:0]  pcq_head;
  logic [OW:0]  pcq_count;
  logic         pcq_full, pcq_empty;

  // Credit rule: every in-flight word must already own a buffer slot.
  assign outst_ok  = 32'(outst_reg) < 32'(MAX_OUTST);
  assign credit_ok = (32'(buf_count) + 32'(outst_reg)) < 32'(FIFO_DEPTH);
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign imem_req_addr = pc_reg;

  assign resp_drop = imem_resp_valid && (drop_reg != '0);
  assign pcq_pop   = imem_resp_valid && (drop_reg == '0) && !pcq_empty;
  assign resp_push = imem_resp_valid && (drop_reg == '0) && !redirect_valid;

  assign inst_valid = !buf_empty && !redirect_valid;
  assign pop_fire   = inst_valid && inst_ready;
  assign inst       = buf_rdata[63:32];
  assign inst_pc    = buf_rdata[31:0];

  always_comb begin
    state_next     = state_reg;
    imem_req_valid = 1'b0;
    if (redirect_valid) begin
      state_next = halt ? FS_HALTED : FS_RUN;
    end else begin
      case (state_reg)
        FS_BOOT:   state_next = FS_RUN;
        FS_RUN:    if (halt) state_next = FS_HALTED;
        FS_HALTED: if (!halt) state_next = FS_RUN;
        default:   state_next = FS_BOOT;
      endcase
    end
    imem_req_valid = (state_reg == FS_RUN) && !redirect_valid && outst_ok && credit_ok;
  end

  always_comb begin
    pc_next    = pc_reg;
    outst_next = outst_reg;
    drop_next  = drop_reg;
    if (redirect_valid)  pc_next = align_word(redirect_pc);
    else if (req_fire)   pc_next = pc_reg + 32'd4;
    case ({req_fire, imem_resp_valid})
      2'b10:   outst_next = outst_reg + 1'b1;
      2'b01:   outst_next = outst_reg - 1'b1;
      default: outst_next = outst_reg;
    endcase
    // Everything still in flight at a redirect belongs to the abandoned path.
    if (redirect_valid)  drop_next = imem_resp_valid ? outst_reg - 1'b1 : outst_reg;
    else if (resp_drop)  drop_next = drop_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FS_BOOT;
      pc_reg    <= RESET_PC;
      outst_reg <= '0;
      drop_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      outst_reg <= outst_next;
      drop_reg  <= drop_next;
    end
  end

  fetch_fifo #(
    .WIDTH    (64),
    .DEPTH    (FIFO_DEPTH),
    .RESET_VAL({INST_NOP, RESET_PC})
  ) u_inst_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .push (resp_push),
    .pop  (pop_fire),
    .flush(redirect_valid),
    .wdata({imem_resp_data, pcq_head}),
    .rdata(buf_rdata),
    .count(buf_count),
    .full (buf_full),
    .empty(buf_empty)
  );

  fetch_fifo #(
    .WIDTH    (32),
    .DEPTH    (MAX_OUTST),
    .RESET_VAL(RESET_PC)
  ) u_pc_queue (
    .clk  (clk),
    .rst_n(rst_n),
    .push (req_fire),
    .pop  (pcq_pop),
    .flush(redirect_valid),
    .wdata(pc_reg),
    .rdata(pcq_head),
    .count(pcq_count),
    .full (pcq_full),
    .empty(pcq_empty)
  );

  a_buf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(resp_push && buf_full && !pop_fire));
  a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(req_fire && pcq_full));
  a_outst_accounting: assert property (@(posedge clk) disable iff (!rst_n)
    (32'(pcq_count) + 32'(drop_reg)) == 32'(outst_reg));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with an in-order variable-latency imem model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          FIFO_DEPTH = 2;
  localparam int          MAX_OUTST  = 2;
  localparam logic [31:0] RST_PC     = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] addr; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  pend_t       pend_q[$];
  exp_t        exp_q[$];
  logic [31:0] exp_next, last_pc, await_pc;
  bit          await_first, seen_first;
  int          cyc, last_due, lat, due, outst_tb, edges, first_edges;
  int          lat_min = 1, lat_max = 1;
  int          accept_cnt, pop_cnt;
  int          n_checks = 0, n_fail = 0;
  exp_t        e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected decode stream: consecutive word PCs starting at the latest restart point.
  task automatic restart_stream(input logic [31:0] target);
    exp_q.delete();
    exp_next = {target[31:2], 2'b00};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{pc: exp_next, data: mem_word(exp_next)});
      exp_next = exp_next + 32'd4;
    end
    await_first = 1'b1;
    await_pc    = {target[31:2], 2'b00};
  endtask

  // Monitor + imem model: sample at negedge, drive responses just after posedge.
  initial begin
    cyc = 0; last_due = 0; edges = 0; accept_cnt = 0; pop_cnt = 0;
    seen_first = 1'b0; last_pc = RST_PC;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    restart_stream(RST_PC);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_inst", inst, INST_NOP);
        check_eq("rst_inst_pc", inst_pc, RST_PC);
        pend_q.delete();
        last_due = 0;
        last_pc  = RST_PC;
        restart_stream(RST_PC);
      end else begin
        outst_tb = pend_q.size() + int'(imem_resp_valid);
        if (imem_req_valid) begin
          check_eq("req_align", 32'(imem_req_addr[1:0]), 32'd0);
          check_eq("req_credit", 32'(outst_tb < MAX_OUTST), 32'd1);
          check_eq("req_during_redirect", 32'(redirect_valid), 32'd0);
        end
        if (redirect_valid)
          check_eq("inst_valid_on_redirect", 32'(inst_valid), 32'd0);
        if (!inst_valid && !redirect_valid)
          check_eq("inst_pc_hold", inst_pc, last_pc);
        if (inst_valid && !seen_first) begin
          seen_first  = 1'b1;
          first_edges = edges;
        end
        if (imem_req_valid && imem_req_ready) begin
          accept_cnt++;
          if (await_first) begin
            check_eq("first_addr_after_restart", imem_req_addr, await_pc);
            await_first = 1'b0;
          end
          lat = int'($urandom_range(lat_min, lat_max));
          due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
          last_due = due;
          pend_q.push_back('{due: due, addr: imem_req_addr});
        end
        if (inst_valid && inst_ready) begin
          pop_cnt++;
          e = exp_q.pop_front();
          exp_q.push_back('{pc: exp_next, data: mem_word(exp_next)});
          exp_next = exp_next + 32'd4;
          check_eq("inst_pc", inst_pc, e.pc);
          check_eq("inst", inst, e.data);
          last_pc = inst_pc;
        end
        if (redirect_valid) restart_stream(redirect_pc);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n) edges++; else edges = 0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      if (rst_n && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    halt = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
    repeat (12) step();
    check_eq("drain_empty", 32'(inst_valid), 32'd0);
    halt = 1'b0;
  endtask

  bit found;
  int a0, p0;

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Streaming from reset with 1-cycle imem.
    repeat (30) step();
    check_eq("first_inst_seen", 32'(seen_first), 32'd1);
    check_eq("first_inst_latency", 32'(first_edges), 32'd3);

    // Decode stall: credits stop issue at exactly FIFO_DEPTH words.
    drain();
    inst_ready = 1'b0;
    a0 = accept_cnt;
    repeat (10) step();
    check_eq("stall_issue_count", 32'(accept_cnt - a0), 32'(FIFO_DEPTH));
    check_eq("stall_req_valid", 32'(imem_req_valid), 32'd0);
    inst_ready = 1'b1;
    repeat (20) step();

    // Redirect with two requests in flight (latency 3).
    drain();
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (pend_q.size() + int'(imem_resp_valid) == 2 && !imem_resp_valid) found = 1'b1;
    end
    check_eq("wait_two_outstanding", 32'(found), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    repeat (25) step();

    // Redirect colliding with a response and a pop attempt; low target bits ignored.
    drain();
    lat_min = 1; lat_max = 1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (imem_resp_valid && inst_valid) found = 1'b1;
    end
    check_eq("wait_resp_and_pop", 32'(found), 32'd1);
    p0 = pop_cnt;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0302;
    step();
    redirect_valid = 1'b0;
    check_eq("no_pop_on_redirect", 32'(pop_cnt - p0), 32'd0);
    repeat (20) step();

    // Address wrap plus random backpressure, latency, halts and redirects.
    lat_min = 1; lat_max = 3;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      inst_ready     = 1'($urandom_range(0, 3) != 0);
      halt           = (i > 60) && ($urandom_range(0, 15) == 0);
      redirect_valid = (i > 60) && ($urandom_range(0, 39) == 0);
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0; imem_req_ready = 1'b1;

    // Halt with one request outstanding: it lands, nothing new issues.
    drain();
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (pend_q.size() + int'(imem_resp_valid) == 1) found = 1'b1;
    end
    check_eq("wait_one_outstanding", 32'(found), 32'd1);
    halt = 1'b1;
    p0 = pop_cnt;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i > 0) check_eq("halt_no_issue", 32'(imem_req_valid), 32'd0);
    end
    check_eq("halt_resp_delivered", 32'(pop_cnt > p0), 32'd1);
    check_eq("halt_outst_zero", 32'(pend_q.size() + int'(imem_resp_valid)), 32'd0);

    // Asynchronous reset in the middle of a burst.
    halt = 1'b0; lat_min = 1; lat_max = 2;
    repeat (5) step();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("async_rst_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("async_rst_inst", inst, INST_NOP);
    check_eq("async_rst_inst_pc", inst_pc, RST_PC);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
